ma_window_scheduler: RTL and testbench

- Sequences the pipelined multiply-adder tree over one feature map.
- Walks kernel-window positions row-major at stride 1 and issues one window per cycle to the tree.
- Tracks the tree's fixed pipeline latency and captures each sum into a local result FIFO.
- Stalls issue, using credits, so that no result is lost when the downstream consumer backpressures. The tree itself cannot stall.

---
 rtl/ma_window_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_ma_window_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_window_scheduler.sv
// Window scheduler for the pipelined multiply-adder tree: walks output positions row-major,
// tracks the tree latency with a tag shift register and buffers sums in a credit-guarded FIFO.
module ma_window_scheduler #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int MA_LATENCY  = 5,
    parameter int SUM_W       = 32,
    parameter int FIFO_DEPTH  = 8,
    localparam int OUT_W = IMG_W - KERNEL_SIZE + 1,
    localparam int OUT_H = IMG_H - KERNEL_SIZE + 1,
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             win_issue,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    input  logic [SUM_W-1:0] ma_sum,
    output logic [SUM_W-1:0] res_data,
    output logic [ROW_W-1:0] res_row,
    output logic [COL_W-1:0] res_col,
    output logic             res_last,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } tag_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } entry_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [CNT_W-1:0] credits_q;
    logic [CNT_W-1:0] fifo_count_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    tag_t             sr_q [MA_LATENCY];
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head;

    logic issue;
    logic pop;
    logic fifo_wr;
    logic fifo_full;
    logic at_last_pos;
    logic sr_busy;

    assign res_valid   = (fifo_count_q != '0);
    assign pop         = res_valid && res_ready;
    assign fifo_wr     = sr_q[MA_LATENCY-1].valid;
    assign fifo_full   = (fifo_count_q == CNT_W'(FIFO_DEPTH));
    assign at_last_pos = (row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1));

    assign win_issue = issue;
    assign win_row   = row_q;
    assign win_col   = col_q;

    always_comb begin
        sr_busy = 1'b0;
        for (int unsigned i = 0; i < MA_LATENCY; i++) begin
            sr_busy = sr_busy | sr_q[i].valid;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pop may free the credit an issue needs in the same cycle, so issue depends on res_ready.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if ((credits_q != '0) || pop) begin
                    issue = 1'b1;
                    if (at_last_pos) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Finish as the final entry leaves, so done follows the last pop by one cycle.
                if (!sr_busy && ((fifo_count_q == '0) || ((fifo_count_q == CNT_W'(1)) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state_q == IDLE && start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (issue) begin
            if (col_q == COL_W'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= at_last_pos ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits_q <= CNT_W'(FIFO_DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   credits_q <= credits_q + 1'b1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MA_LATENCY; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0].valid <= issue;
            sr_q[0].row   <= row_q;
            sr_q[0].col   <= col_q;
            sr_q[0].last  <= at_last_pos;
            for (int unsigned i = 1; i < MA_LATENCY; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({fifo_wr, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
                2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q].sum  <= ma_sum;
            mem_q[wr_ptr_q].row  <= sr_q[MA_LATENCY-1].row;
            mem_q[wr_ptr_q].col  <= sr_q[MA_LATENCY-1].col;
            mem_q[wr_ptr_q].last <= sr_q[MA_LATENCY-1].last;
        end
    end

    // Storage is not reset; gating by res_valid keeps outputs at zero while empty.
    assign head     = mem_q[rd_ptr_q];
    assign res_data = res_valid ? head.sum  : '0;
    assign res_row  = res_valid ? head.row  : '0;
    assign res_col  = res_valid ? head.col  : '0;
    assign res_last = res_valid ? head.last : 1'b0;

    fifo_no_overflow : assert property (@(posedge clock) disable iff (!reset)
        !(fifo_wr && fifo_full && !pop));

endmodule

// File: tb/tb_ma_window_scheduler.sv
// Scoreboard bench: a 4x4 instance for the basic pass, a default 8x8 instance for
// backpressure, credit boundary, random ready, reset mid-pass and throughput.
module tb_ma_window_scheduler;

    localparam int LAT  = 5;
    localparam int OW   = 6;
    localparam int NPIX = 36;
    localparam int SOW  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Default-size instance
    logic        start, busy, done, win_issue, res_last, res_valid, res_ready;
    logic [2:0]  win_row, win_col, res_row, res_col;
    logic [31:0] ma_sum, res_data;

    ma_window_scheduler dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .win_issue(win_issue), .win_row(win_row), .win_col(win_col), .ma_sum(ma_sum),
        .res_data(res_data), .res_row(res_row), .res_col(res_col), .res_last(res_last),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    // 4x4 instance
    logic        s_start, s_busy, s_done, s_win_issue, s_res_last, s_res_valid, s_res_ready;
    logic [0:0]  s_win_row, s_win_col, s_res_row, s_res_col;
    logic [31:0] s_ma_sum, s_res_data;

    ma_window_scheduler #(.IMG_W(4), .IMG_H(4)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .win_issue(s_win_issue), .win_row(s_win_row), .win_col(s_win_col), .ma_sum(s_ma_sum),
        .res_data(s_res_data), .res_row(s_res_row), .res_col(s_res_col), .res_last(s_res_last),
        .res_valid(s_res_valid), .res_ready(s_res_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          row;
        int          col;
        bit          last;
    } exp_t;

    exp_t sb_q[$];
    exp_t ssb_q[$];

    // Tree models: sum = pass base + issue index, presented LAT cycles after issue
    int          pass_base = 0;
    int          tree_idx = 0;
    logic [31:0] pipe [LAT];
    always @(posedge clock) begin
        if (start && !busy) tree_idx <= 0;
        else if (win_issue) tree_idx <= tree_idx + 1;
        pipe[0] <= win_issue ? 32'(pass_base + tree_idx) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ma_sum = pipe[LAT-1];

    int          s_tree_idx = 0;
    logic [31:0] s_pipe [LAT];
    always @(posedge clock) begin
        if (s_start && !s_busy) s_tree_idx <= 0;
        else if (s_win_issue) s_tree_idx <= s_tree_idx + 1;
        s_pipe[0] <= s_win_issue ? 32'(100 + s_tree_idx) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) s_pipe[i] <= s_pipe[i-1];
    end
    assign s_ma_sum = s_pipe[LAT-1];

    // Monitor, default instance
    int mon_idx = 0, pops = 0, dones = 0;
    int first_issue = -1, last_issue = -1, first_valid = -1;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (start && !busy) begin
                mon_idx     = 0;
                first_issue = -1;
                first_valid = -1;
            end
            if (win_issue) begin
                check("issue_row", 32'(win_row), 32'(mon_idx / OW));
                check("issue_col", 32'(win_col), 32'(mon_idx % OW));
                if (first_issue < 0) first_issue = cyc;
                last_issue = cyc;
                mon_idx++;
            end
            if (res_valid && first_valid < 0) first_valid = cyc;
            if (res_valid && res_ready) begin
                check("pop_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_tag", {res_row, res_col, res_last}, {e.row[2:0], e.col[2:0], e.last});
                end
                pops++;
            end
            if (done) dones++;
        end
    end

    // Monitor, 4x4 instance
    int s_mon_idx = 0, s_dones = 0, s_last_pop = -1, s_first_issue = -1, s_last_issue = -1;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (s_start && !s_busy) begin
                s_mon_idx     = 0;
                s_first_issue = -1;
            end
            if (s_win_issue) begin
                check("s_issue_row", 32'(s_win_row), 32'(s_mon_idx / SOW));
                check("s_issue_col", 32'(s_win_col), 32'(s_mon_idx % SOW));
                if (s_first_issue < 0) s_first_issue = cyc;
                s_last_issue = cyc;
                s_mon_idx++;
            end
            if (s_res_valid && s_res_ready) begin
                check("s_pop_expected", 32'(ssb_q.size() != 0), 32'd1);
                if (ssb_q.size() != 0) begin
                    e = ssb_q.pop_front();
                    check("s_res_data", s_res_data, e.data);
                    check("s_res_tag", {s_res_row, s_res_col, s_res_last},
                          {e.row[0], e.col[0], e.last});
                end
                s_last_pop = cyc;
            end
            if (s_done) begin
                check("s_done_timing", 32'(cyc), 32'(s_last_pop + 1));
                s_dones++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_pass(input int base);
        exp_t e;
        for (int k = 0; k < NPIX; k++) begin
            e.data = 32'(base + k);
            e.row  = k / OW;
            e.col  = k % OW;
            e.last = (k == NPIX - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {15'd0, busy, done, win_issue, win_row, win_col,
                               res_valid, res_last, res_row, res_col}, 32'd0);
        check({tag, "_data"}, res_data, 32'd0);
        check({tag, "_s_ctrl"}, {21'd0, s_busy, s_done, s_win_issue, s_win_row, s_win_col,
                                 s_res_valid, s_res_last, s_res_row, s_res_col}, 32'd0);
        check({tag, "_s_data"}, s_res_data, 32'd0);
    endtask

    task automatic wait_dones(input int target, input int budget);
        for (int i = 0; i < budget && dones < target; i++) tick(1);
        check("done_reached", 32'(dones >= target), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   pops0;
        start = 1'b0; res_ready = 1'b0; s_start = 1'b0; s_res_ready = 1'b0;
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b1;
        tick(2);

        // Basic 4x4 pass
        for (int k = 0; k < 4; k++) begin
            e.data = 32'(100 + k); e.row = k / SOW; e.col = k % SOW; e.last = (k == 3);
            ssb_q.push_back(e);
        end
        s_res_ready = 1'b1;
        s_start = 1'b1; tick(1); s_start = 1'b0;
        for (int i = 0; i < 60 && s_dones == 0; i++) tick(1);
        tick(5);
        check("s_issue_count", 32'(s_mon_idx), 32'd4);
        check("s_issue_span", 32'(s_last_issue - s_first_issue), 32'd3);
        check("s_sb_empty", 32'(ssb_q.size()), 32'd0);
        check("s_done_count", 32'(s_dones), 32'd1);

        // Backpressure from start, then credit boundary
        pass_base = 1000;
        push_pass(pass_base);
        res_ready = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(30);
        check("bp_issues", 32'(mon_idx), 32'd8);
        check("bp_valid", 32'(res_valid), 32'd1);
        check("bp_no_issue", 32'(win_issue), 32'd0);
        start = 1'b1; tick(1); start = 1'b0;
        pops0 = pops;
        res_ready = 1'b1;
        #1;
        check("cb_issue_with_pop", 32'(win_issue), 32'd1);
        tick(1);
        res_ready = 1'b0;
        tick(LAT + 3);
        check("cb_issues", 32'(mon_idx), 32'd9);
        check("cb_pops", 32'(pops - pops0), 32'd1);
        check("cb_still_full", 32'(res_valid), 32'd1);
        check("cb_no_credit", 32'(win_issue), 32'd0);

        // Random ready to completion, with start pulses while busy
        for (int i = 0; i < 3000 && dones < 1; i++) begin
            res_ready = 1'($urandom_range(0, 1));
            start = busy && (i % 7 == 3);
            tick(1);
        end
        start = 1'b0; res_ready = 1'b0;
        check("rand_done", 32'(dones), 32'd1);
        tick(10);
        check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        check("rand_pops", 32'(pops), 32'(NPIX));
        check("rand_single_done", 32'(dones), 32'd1);
        check("rand_idle", 32'(busy), 32'd0);

        // Reset in the middle of a pass
        pass_base = 2000;
        push_pass(pass_base);
        res_ready = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 100 && mon_idx < 10; i++) tick(1);
        check("mid_issue_reached", 32'(mon_idx >= 10), 32'd1);
        reset = 1'b0;
        #1;
        check_outputs_zero("midrst");
        sb_q.delete();
        tick(3);
        reset = 1'b1;
        tick(2);

        // Fresh full-rate pass after reset
        pass_base = 3000;
        push_pass(pass_base);
        res_ready = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        wait_dones(2, 300);
        tick(5);
        check("post_sb_empty", 32'(sb_q.size()), 32'd0);
        check("post_issue_count", 32'(mon_idx), 32'(NPIX));
        check("post_no_bubbles", 32'(last_issue - first_issue), 32'(NPIX - 1));
        check("post_first_valid", 32'(first_valid - first_issue), 32'(LAT + 1));
        check("post_done_count", 32'(dones), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
